// File: rtl/matrix_acc_pkg.sv
// matrix_accumulate shared package
// Default sizes, FSM state type and lane slicing helper.
package matrix_acc_pkg;

  localparam int ELEMS_D  = 16;
  localparam int PROD_W_D = 32;
  localparam int ACC_W_D  = 40;
  localparam int BATCH_D  = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Low bit of lane idx on a bus of width-wide lanes.
  function automatic int lane_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/acc_lane.sv
// matrix_accumulate single accumulator lane
// One wrapping register with adder and carry-out.
module acc_lane
  import matrix_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_D
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             add_en,
  input  logic [ACC_W-1:0] addend,
  output logic [ACC_W-1:0] value,
  output logic             carry
);

  logic [ACC_W-1:0] value_q;
  logic [ACC_W:0]   sum;

  assign sum   = {1'b0, value_q} + {1'b0, addend};
  assign carry = sum[ACC_W];
  assign value = value_q;

  // Clear wins over add; the sum wraps modulo 2^ACC_W.
  always_ff @(posedge clk) begin
    if (clear) begin
      value_q <= '0;
    end else if (add_en) begin
      value_q <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/matrix_accumulate.sv
// matrix_accumulate top
// Batch FSM, beat count, sticky overflow and output handshake.
module matrix_accumulate
  import matrix_acc_pkg::*;
#(
  parameter int ELEMS  = ELEMS_D,
  parameter int PROD_W = PROD_W_D,
  parameter int ACC_W  = ACC_W_D,
  parameter int BATCH  = BATCH_D,
  localparam int CNT_W = $clog2(BATCH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ELEMS*PROD_W-1:0] in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ELEMS*ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_ovf
);

  localparam logic [CNT_W-1:0] BATCH_C = CNT_W'(BATCH);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_q;
  logic             accept;
  logic             clear;
  logic             last_beat;
  logic [ELEMS-1:0] carry;

  assign cnt_inc   = count_q + 1'b1;
  assign last_beat = (cnt_inc == BATCH_C);

  assign out_count = count_q;
  assign out_ovf   = ovf_q;

  // One lane per matrix element, addend zero-extended.
  for (genvar i = 0; i < ELEMS; i++) begin : g_lane
    acc_lane #(
      .ACC_W (ACC_W)
    ) u_lane (
      .clk    (clk),
      .clear  (clear),
      .add_en (accept),
      .addend (ACC_W'(in_data[lane_lo(i, PROD_W) +: PROD_W])),
      .value  (out_data[lane_lo(i, ACC_W) +: ACC_W]),
      .carry  (carry[i])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    clear     = reset;
    unique case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept && last_beat) begin
          state_d = HOLD;
        end else if (flush &&
                     (in_valid || count_q != '0)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          clear   = 1'b1;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Beat count and sticky lane-wrap flag.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      count_q <= cnt_inc;
      ovf_q   <= ovf_q | (|carry);
    end
  end

endmodule

// File: tb/tb_matrix_accumulate.sv
// matrix_accumulate testbench
// Directed vectors on a default instance and a narrow-lane instance.
module tb_matrix_accumulate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: ACC_W=40, BATCH=4.
  logic         a_reset, a_in_valid, a_in_ready, a_flush;
  logic         a_out_valid, a_out_ready, a_out_ovf;
  logic [511:0] a_in_data;
  logic [639:0] a_out_data;
  logic [2:0]   a_out_count;

  matrix_accumulate u_a (
    .clk       (clk),
    .reset     (a_reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .flush     (a_flush),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_count (a_out_count),
    .out_ovf   (a_out_ovf)
  );

  // Narrow instance: ACC_W=33, BATCH=3.
  logic         b_reset, b_in_valid, b_in_ready, b_flush;
  logic         b_out_valid, b_out_ready, b_out_ovf;
  logic [511:0] b_in_data;
  logic [527:0] b_out_data;
  logic [1:0]   b_out_count;

  matrix_accumulate #(
    .ACC_W (33),
    .BATCH (3)
  ) u_b (
    .clk       (clk),
    .reset     (b_reset),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .flush     (b_flush),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_count (b_out_count),
    .out_ovf   (b_out_ovf)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic        fl;
    logic        ordy;
    logic        md;
    logic [31:0] dv;
    logic        e_ov;
    logic        e_ir;
    logic [2:0]  e_cnt;
    logic        e_ovf;
    logic [39:0] e_a;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(
    input logic rst, input logic iv, input logic fl,
    input logic ordy, input logic md, input logic [31:0] dv,
    input logic e_ov, input logic e_ir, input logic [2:0] e_cnt,
    input logic e_ovf, input logic [39:0] e_a);
    vec_t v;
    v.rst = rst; v.iv = iv; v.fl = fl; v.ordy = ordy;
    v.md = md; v.dv = dv; v.e_ov = e_ov; v.e_ir = e_ir;
    v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_a = e_a;
    return v;
  endfunction

  // md=1: element i = dv*(i+1); md=0: every element = dv.
  function automatic logic [511:0] din(input logic md,
                                       input logic [31:0] dv);
    logic [511:0] r;
    for (int i = 0; i < 16; i++)
      r[i*32 +: 32] = md ? dv * 32'(i + 1) : dv;
    return r;
  endfunction

  function automatic logic [639:0] exp_a(input logic md,
                                         input logic [39:0] a);
    logic [639:0] r;
    for (int i = 0; i < 16; i++)
      r[i*40 +: 40] = md ? a * 40'(i + 1) : a;
    return r;
  endfunction

  function automatic logic [527:0] exp_b(input logic [32:0] a);
    logic [527:0] r;
    for (int i = 0; i < 16; i++)
      r[i*33 +: 33] = a;
    return r;
  endfunction

  task automatic chk(input string name, input int row,
                     input logic [639:0] act,
                     input logic [639:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h",
               name, row, act, exp);
    end
  endtask

  task automatic b_step(input logic rst, input logic iv,
                        input logic [31:0] dv, input logic ordy);
    b_reset     = rst;
    b_in_valid  = iv;
    b_in_data   = din(1'b0, dv);
    b_out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_reset = 1'b1; a_in_valid = 1'b0; a_flush = 1'b0;
    a_out_ready = 1'b0; a_in_data = '0;
    b_reset = 1'b1; b_in_valid = 1'b0; b_flush = 1'b0;
    b_out_ready = 1'b0; b_in_data = '0;

    // Reset state.
    vq.push_back(mk(1,0,0,0,0,0, 0,1,0,0,0));
    // Four beats of element i = i+1.
    vq.push_back(mk(0,1,0,0,1,1, 0,1,1,0,1));
    vq.push_back(mk(0,1,0,0,1,1, 0,1,2,0,2));
    vq.push_back(mk(0,1,0,0,1,1, 0,1,3,0,3));
    vq.push_back(mk(0,1,0,0,1,1, 1,0,4,0,4));
    // Back-pressure: extra beats ignored, output stable.
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(0,1,0,0,1,1, 1,0,4,0,4));
    vq.push_back(mk(0,1,0,1,1,1, 0,1,0,0,0));
    // Next batch starts from zero.
    vq.push_back(mk(0,1,0,0,1,1, 0,1,1,0,1));
    vq.push_back(mk(0,1,0,0,1,1, 0,1,2,0,2));
    vq.push_back(mk(0,1,0,0,1,1, 0,1,3,0,3));
    vq.push_back(mk(0,1,0,0,1,1, 1,0,4,0,4));
    vq.push_back(mk(0,0,0,1,1,1, 0,1,0,0,0));
    // Flush with the third beat; flush in HOLD has no effect.
    vq.push_back(mk(0,1,0,0,0,1, 0,1,1,0,1));
    vq.push_back(mk(0,1,0,0,0,1, 0,1,2,0,2));
    vq.push_back(mk(0,1,1,0,0,1, 1,0,3,0,3));
    vq.push_back(mk(0,1,1,0,0,1, 1,0,3,0,3));
    vq.push_back(mk(0,0,0,1,0,1, 0,1,0,0,0));
    // Idle flush ignored; out_ready ignored in ACCUM.
    vq.push_back(mk(0,0,1,0,0,1, 0,1,0,0,0));
    vq.push_back(mk(0,0,1,1,0,1, 0,1,0,0,0));
    // Flush with a beat on an empty batch.
    vq.push_back(mk(0,1,1,0,0,5, 1,0,1,0,5));
    vq.push_back(mk(0,0,0,1,0,0, 0,1,0,0,0));
    // Mid-batch reset discards the partial batch.
    vq.push_back(mk(0,1,0,0,0,1, 0,1,1,0,1));
    vq.push_back(mk(0,1,0,0,0,1, 0,1,2,0,2));
    vq.push_back(mk(1,1,0,0,0,1, 0,1,0,0,0));
    vq.push_back(mk(0,1,0,0,0,1, 0,1,1,0,1));
    vq.push_back(mk(0,1,0,0,0,1, 0,1,2,0,2));
    vq.push_back(mk(0,1,0,0,0,1, 0,1,3,0,3));
    vq.push_back(mk(0,1,0,0,0,1, 1,0,4,0,4));
    vq.push_back(mk(0,1,0,1,0,1, 0,1,0,0,0));

    @(negedge clk);
    foreach (vq[r]) begin
      a_reset     = vq[r].rst;
      a_in_valid  = vq[r].iv;
      a_flush     = vq[r].fl;
      a_out_ready = vq[r].ordy;
      a_in_data   = din(vq[r].md, vq[r].dv);
      @(posedge clk);
      #1;
      chk("a_out_valid", r, 640'(a_out_valid), 640'(vq[r].e_ov));
      chk("a_in_ready", r, 640'(a_in_ready), 640'(vq[r].e_ir));
      chk("a_out_count", r, 640'(a_out_count), 640'(vq[r].e_cnt));
      chk("a_out_ovf", r, 640'(a_out_ovf), 640'(vq[r].e_ovf));
      chk("a_out_data", r, a_out_data,
          exp_a(vq[r].md, vq[r].e_a));
      @(negedge clk);
    end
    a_reset = 1'b0; a_in_valid = 1'b0;

    // Narrow lanes: three beats of all-ones wrap at 33 bits.
    b_step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("b_reset_valid", 0, 640'(b_out_valid), 640'(0));
    b_step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("b_ovf_beat1", 1, 640'(b_out_ovf), 640'(0));
    b_step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("b_ovf_beat2", 2, 640'(b_out_ovf), 640'(0));
    chk("b_data_beat2", 2, 640'(b_out_data),
        640'(exp_b(33'h1_FFFF_FFFE)));
    b_step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("b_valid_wrap", 3, 640'(b_out_valid), 640'(1));
    chk("b_count_wrap", 3, 640'(b_out_count), 640'(3));
    chk("b_ovf_wrap", 3, 640'(b_out_ovf), 640'(1));
    chk("b_data_wrap", 3, 640'(b_out_data),
        640'(exp_b(33'h0_FFFF_FFFD)));
    b_step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("b_ovf_clear", 4, 640'(b_out_ovf), 640'(0));
    chk("b_data_clear", 4, 640'(b_out_data), 640'(0));
    for (int k = 0; k < 3; k++)
      b_step(1'b0, 1'b1, 32'h1, 1'b0);
    chk("b_valid_ones", 5, 640'(b_out_valid), 640'(1));
    chk("b_count_ones", 5, 640'(b_out_count), 640'(3));
    chk("b_ovf_ones", 5, 640'(b_out_ovf), 640'(0));
    chk("b_data_ones", 5, 640'(b_out_data),
        640'(exp_b(33'd3)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
